// File: rtl/seq_loader.sv
// Buffered serial sequence loader: stores words, then shifts them out
// MSB first as framed sclk/sync/dataOut bursts and signals completion.
module seq_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 22,
  parameter int DIV   = 4,
  parameter int GAP   = 4
) (
  input  logic             mainclk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  output logic             sclk,
  output logic             sync,
  output logic             dataOut,
  output logic             enable,
  output logic             busy,
  output logic [4:0]       count,
  output logic             err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(DIV);
  localparam int GW = $clog2(GAP);
  localparam int WW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [4:0]    FULL     = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAPW,
    RUN
  } state_t;

  state_t state;
  state_t nextState;

  logic [BW-1:0] bitCnt;
  logic [BW-1:0] nextBit;
  logic [DW-1:0] divCnt;
  logic [DW-1:0] nextDiv;
  logic [GW-1:0] gapCnt;
  logic [GW-1:0] nextGap;
  logic [WW-1:0] wordIdx;
  logic [WW-1:0] nextWord;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] curWord;

  logic isIdle;
  logic startOk;
  logic clrOk;
  logic wrOk;
  logic errNext;
  logic lastWord;

  logic sclkNext;
  logic syncNext;
  logic dataNext;
  logic enableNext;
  logic busyNext;

  assign isIdle   = (state == IDLE);
  assign clrOk    = isIdle && clear;
  assign wrOk     = isIdle && wr_en && !clear && (count != FULL);
  assign startOk  = isIdle && start && !stop && !clear && (count != 5'd0);
  assign lastWord = (5'(wordIdx) == (count - 5'd1));

  // stop masks start; clear masks wr_en; anything else unaccepted is an error
  assign errNext = (wr_en && !clrOk && !wrOk)
                 || (clear && !isIdle)
                 || (start && !stop && !startOk);

  always_ff @(posedge mainclk) begin
    if (reset) begin
      state   <= IDLE;
      bitCnt  <= '0;
      divCnt  <= '0;
      gapCnt  <= '0;
      wordIdx <= '0;
    end else begin
      state   <= nextState;
      bitCnt  <= nextBit;
      divCnt  <= nextDiv;
      gapCnt  <= nextGap;
      wordIdx <= nextWord;
    end
  end

  always_comb begin
    nextState = state;
    nextBit   = bitCnt;
    nextDiv   = divCnt;
    nextGap   = gapCnt;
    nextWord  = wordIdx;
    unique case (state)
      IDLE: begin
        if (startOk) begin
          nextState = FRAME;
          nextBit   = '0;
          nextDiv   = '0;
          nextWord  = '0;
        end
      end
      FRAME: begin
        if (stop) begin
          nextState = IDLE;
        end else if (divCnt == DIV_LAST) begin
          nextDiv = '0;
          if (bitCnt == BIT_LAST) begin
            nextState = GAPW;
            nextGap   = '0;
          end else begin
            nextBit = bitCnt + 1'b1;
          end
        end else begin
          nextDiv = divCnt + 1'b1;
        end
      end
      GAPW: begin
        if (stop) begin
          nextState = IDLE;
        end else if (gapCnt == GAP_LAST) begin
          if (lastWord) begin
            nextState = RUN;
          end else begin
            nextState = FRAME;
            nextWord  = wordIdx + 1'b1;
            nextBit   = '0;
            nextDiv   = '0;
          end
        end else begin
          nextGap = gapCnt + 1'b1;
        end
      end
      RUN: begin
        if (stop) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up
  always_comb begin
    curWord    = mem[nextWord];
    sclkNext   = 1'b0;
    syncNext   = 1'b1;
    dataNext   = 1'b0;
    enableNext = 1'b0;
    busyNext   = 1'b0;
    unique case (nextState)
      FRAME: begin
        syncNext = 1'b0;
        sclkNext = (nextDiv == DIV_LAST);
        dataNext = curWord[BIT_LAST - nextBit];
        busyNext = 1'b1;
      end
      GAPW: busyNext = 1'b1;
      RUN:  enableNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge mainclk) begin
    if (reset) begin
      sclk    <= 1'b0;
      sync    <= 1'b1;
      dataOut <= 1'b0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      sclk    <= sclkNext;
      sync    <= syncNext;
      dataOut <= dataNext;
      enable  <= enableNext;
      busy    <= busyNext;
      err     <= errNext;
    end
  end

  always_ff @(posedge mainclk) begin
    if (reset) begin
      count <= 5'd0;
    end else if (clrOk) begin
      count <= 5'd0;
    end else if (wrOk) begin
      count <= count + 5'd1;
    end
  end

  always_ff @(posedge mainclk) begin
    if (!reset && wrOk) mem[count[WW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader at default parameters.
// Checks framing, replay, full buffer, rejects, abort and reset.
module tb_seq_loader;

  logic        mainclk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        clear;
  logic        start;
  logic        stop;
  logic        sclk;
  logic        sync;
  logic        dataOut;
  logic        enable;
  logic        busy;
  logic [4:0]  count;
  logic        err;

  int tests = 0;
  int fails = 0;

  seq_loader dut (
    .mainclk(mainclk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clear(clear),
    .start(start),
    .stop(stop),
    .sclk(sclk),
    .sync(sync),
    .dataOut(dataOut),
    .enable(enable),
    .busy(busy),
    .count(count),
    .err(err)
  );

  always #5 mainclk = ~mainclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge mainclk);
    #1;
  endtask

  task automatic write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick;
    wr_en   = 1'b0;
  endtask

  task automatic pulseStart;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic pulseStop;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  // Sample one 128-cycle frame starting at its first cycle
  task automatic sendFrame(output logic [31:0] w, output int pulses,
                           output int lows, output int bad);
    logic prev;
    w = '0;
    pulses = 0;
    lows = 0;
    bad = 0;
    prev = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (sync === 1'b0) lows++;
      if (sclk === 1'b1) begin
        pulses++;
        w = {w[30:0], dataOut};
      end
      if (sclk !== ((i % 4) == 3)) bad++;
      if ((i % 4) != 0 && dataOut !== prev) bad++;
      if (busy !== 1'b1 || enable !== 1'b0) bad++;
      prev = dataOut;
      tick;
    end
  endtask

  task automatic gapRun(output int bad);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(sync === 1'b1 && sclk === 1'b0 && dataOut === 1'b0
            && busy === 1'b1 && enable === 1'b0)) bad++;
      tick;
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1357_0000 + i * 32'h0001_0111;
  endfunction

  logic [31:0] w;
  int pulses;
  int lows;
  int bad;
  int cnt;

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    clear   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sync", 32'(sync), 1);
    check("rst_data", 32'(dataOut), 0);
    check("rst_en", 32'(enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    check("rst_err", 32'(err), 0);

    pulseStart;
    check("empty_start_err", 32'(err), 1);
    check("empty_start_sync", 32'(sync), 1);
    check("empty_start_busy", 32'(busy), 0);
    tick;
    check("err_one_cycle", 32'(err), 0);

    pulseStop;
    check("idle_stop_err", 32'(err), 0);

    write(32'hA500_0301);
    check("wr1_count", 32'(count), 1);
    check("wr1_err", 32'(err), 0);

    pulseStart;
    check("start_busy", 32'(busy), 1);
    sendFrame(w, pulses, lows, bad);
    check("single_word", w, 32'hA500_0301);
    check("single_pulses", 32'(pulses), 32);
    check("single_synclow", 32'(lows), 128);
    check("single_timing", 32'(bad), 0);
    gapRun(bad);
    check("single_gap", 32'(bad), 0);
    check("enable_133", 32'(enable), 1);
    check("run_busy", 32'(busy), 0);
    check("run_sync", 32'(sync), 1);
    tick;
    check("run_hold", 32'(enable), 1);

    pulseStart;
    check("run_start_err", 32'(err), 1);
    check("run_start_en", 32'(enable), 1);

    pulseStop;
    check("stop_run_en", 32'(enable), 0);
    check("stop_run_count", 32'(count), 1);
    pulseStart;
    sendFrame(w, pulses, lows, bad);
    check("replay_word", w, 32'hA500_0301);
    check("replay_timing", 32'(bad), 0);
    gapRun(bad);
    check("replay_en", 32'(enable), 1);
    pulseStop;

    clear = 1'b1;
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    tick;
    clear = 1'b0;
    wr_en = 1'b0;
    check("clear_wins", 32'(count), 0);
    check("clear_err", 32'(err), 0);

    for (int i = 0; i < 22; i++) write(pat(i));
    check("full_count", 32'(count), 22);
    write(32'hFFFF_FFFF);
    check("full_err", 32'(err), 1);
    check("full_hold", 32'(count), 22);

    pulseStart;
    cnt = 0;
    for (int f = 0; f < 22; f++) begin
      sendFrame(w, pulses, lows, bad);
      if (w !== pat(f) || bad != 0 || pulses != 32) cnt++;
      gapRun(bad);
      if (bad != 0) cnt++;
    end
    check("full_frames", 32'(cnt), 0);
    check("full_enable", 32'(enable), 1);
    pulseStop;

    clear = 1'b1;
    tick;
    clear = 1'b0;
    write(32'h0000_00F1);
    write(32'h8000_0002);
    write(32'h5555_AAAA);
    check("three_count", 32'(count), 3);

    pulseStart;
    for (int i = 0; i < 5; i++) tick;
    write(32'h1234_5678);
    check("frame_wr_err", 32'(err), 1);
    check("frame_wr_count", 32'(count), 3);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("frame_clr_err", 32'(err), 1);
    check("frame_clr_count", 32'(count), 3);
    pulseStop;
    check("stop1_sync", 32'(sync), 1);
    check("stop1_busy", 32'(busy), 0);

    start = 1'b1;
    stop  = 1'b1;
    tick;
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", 32'(busy), 0);
    check("start_stop_err", 32'(err), 0);

    pulseStart;
    sendFrame(w, pulses, lows, bad);
    check("abort_f1", w, 32'h0000_00F1);
    gapRun(bad);
    pulses = 0;
    for (int i = 0; i < 42; i++) begin
      if (sclk === 1'b1) pulses++;
      tick;
    end
    check("abort_pre_pulses", 32'(pulses), 10);
    pulseStop;
    check("abort_sync", 32'(sync), 1);
    check("abort_sclk", 32'(sclk), 0);
    check("abort_data", 32'(dataOut), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_count", 32'(count), 3);
    pulses = 0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (sclk === 1'b1) pulses++;
      if (enable !== 1'b0 || sync !== 1'b1) cnt++;
      tick;
    end
    check("abort_no_sclk", 32'(pulses), 0);
    check("abort_quiet", 32'(cnt), 0);

    write(32'h0BAD_0BAD);
    check("abort_idle_wr", 32'(count), 4);

    pulseStart;
    for (int i = 0; i < 20; i++) tick;
    check("mid_sync_low", 32'(sync), 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mrst_sclk", 32'(sclk), 0);
    check("mrst_sync", 32'(sync), 1);
    check("mrst_data", 32'(dataOut), 0);
    check("mrst_en", 32'(enable), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_count", 32'(count), 0);
    check("mrst_err", 32'(err), 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (sclk === 1'b1 || sync !== 1'b1) pulses++;
      tick;
    end
    check("mrst_quiet", 32'(pulses), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
